// File: rtl/uart_periph.sv
// uart_periph: memory-mapped 8N1 UART for the pipeline MEM stage.
// TXD/RXD/CON registers, 16x oversampled TX and RX engines sharing one
// baud tick, sticky status flags and a level interrupt.
module uart_periph #(
    parameter int BAUD_DIV = 325
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        Uart_Rx,
    output logic        Uart_Tx,
    output logic        irq
);

    localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;
    localparam int          CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [CW-1:0] r_baud_cnt;
    logic          w_tick;

    logic [1:0]    r_tx_state;
    logic [3:0]    r_tx_tcnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_shift;
    logic          r_tx;

    logic [1:0]    r_rx_sync;
    logic          r_rx_prev;
    logic [1:0]    r_rx_state;
    logic [3:0]    r_rx_tcnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic [7:0]    r_rxd;

    logic          r_tx_int_en;
    logic          r_rx_int_en;
    logic          r_tx_done;
    logic          r_rx_valid;
    logic          r_frame_err;
    logic          r_overrun;

    logic w_sel_txd, w_sel_rxd, w_sel_con;
    logic w_wr_txd, w_wr_con, w_rd_rxd, w_rd_con;
    logic w_tx_busy, w_tx_end;
    logic w_rx_in, w_rx_fall, w_rx_stop_smp, w_rx_ok, w_rx_bad;
    logic w_unused;

    assign w_sel_txd = (address == ADDR_TXD);
    assign w_sel_rxd = (address == ADDR_RXD);
    assign w_sel_con = (address == ADDR_CON);
    assign w_wr_txd  = write_enable & w_sel_txd;
    assign w_wr_con  = write_enable & w_sel_con;
    assign w_rd_rxd  = read_enable & w_sel_rxd;
    assign w_rd_con  = read_enable & w_sel_con;
    // Only the low byte of a store ever reaches a register.
    assign w_unused  = &{1'b0, writedata[31:8]};

    assign w_tick    = (r_baud_cnt == CW'(BAUD_DIV - 1));

    // Free-running oversample divider; TX and RX both count its wrap pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      r_baud_cnt <= '0;
        else if (w_tick) r_baud_cnt <= '0;
        else             r_baud_cnt <= r_baud_cnt + CW'(1);
    end

    assign w_tx_busy = (r_tx_state != S_IDLE);
    assign w_tx_end  = (r_tx_state == S_STOP) && w_tick && (r_tx_tcnt == 4'd15);

    // TX engine: each bit lasts 16 ticks; the start bit begins on the write edge,
    // so it can be short by up to one tick period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= S_IDLE;
            r_tx_tcnt  <= 4'd0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'd0;
            r_tx       <= 1'b1;
        end else begin
            case (r_tx_state)
                S_IDLE: begin
                    if (w_wr_txd) begin
                        r_tx_state <= S_START;
                        r_tx_shift <= writedata[7:0];
                        r_tx_tcnt  <= 4'd0;
                        r_tx       <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_tx_tcnt <= r_tx_tcnt + 4'd1;
                        if (r_tx_tcnt == 4'd15) begin
                            r_tx_state <= S_DATA;
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx_bit   <= 3'd0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_tx_tcnt <= r_tx_tcnt + 4'd1;
                        if (r_tx_tcnt == 4'd15) begin
                            if (r_tx_bit == 3'd7) begin
                                r_tx_state <= S_STOP;
                                r_tx       <= 1'b1;
                            end else begin
                                r_tx       <= r_tx_shift[0];
                                r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                                r_tx_bit   <= r_tx_bit + 3'd1;
                            end
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_tx_tcnt <= r_tx_tcnt + 4'd1;
                        if (r_tx_tcnt == 4'd15) r_tx_state <= S_IDLE;
                    end
                end
                default: r_tx_state <= S_IDLE;
            endcase
        end
    end

    assign Uart_Tx = r_tx;

    // Two-flop synchronizer plus one history flop for falling-edge detection;
    // reset to the idle-high level so release never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_sync <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_sync <= {r_rx_sync[0], Uart_Rx};
            r_rx_prev <= r_rx_sync[1];
        end
    end

    assign w_rx_in       = r_rx_sync[1];
    assign w_rx_fall     = r_rx_prev & ~w_rx_in;
    assign w_rx_stop_smp = (r_rx_state == S_STOP) && w_tick && (r_rx_tcnt == 4'd15);
    assign w_rx_ok       = w_rx_stop_smp & w_rx_in;
    assign w_rx_bad      = w_rx_stop_smp & ~w_rx_in;

    // RX engine: mid-sample the start bit at tick 8, then every 16 ticks after.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state <= S_IDLE;
            r_rx_tcnt  <= 4'd0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'd0;
        end else begin
            case (r_rx_state)
                S_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_state <= S_START;
                        r_rx_tcnt  <= 4'd0;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_rx_tcnt <= r_rx_tcnt + 4'd1;
                        if (r_rx_tcnt == 4'd7) begin
                            if (w_rx_in) begin
                                r_rx_state <= S_IDLE;
                            end else begin
                                r_rx_state <= S_DATA;
                                r_rx_tcnt  <= 4'd0;
                                r_rx_bit   <= 3'd0;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_rx_tcnt <= r_rx_tcnt + 4'd1;
                        if (r_rx_tcnt == 4'd15) begin
                            r_rx_shift <= {w_rx_in, r_rx_shift[7:1]};
                            if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
                            else                  r_rx_bit   <= r_rx_bit + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_rx_tcnt <= r_rx_tcnt + 4'd1;
                        if (r_rx_tcnt == 4'd15) r_rx_state <= S_IDLE;
                    end
                end
                default: r_rx_state <= S_IDLE;
            endcase
        end
    end

    // Control/status: set events take priority over read-to-clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_int_en <= 1'b0;
            r_rx_int_en <= 1'b0;
            r_tx_done   <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_rxd       <= 8'd0;
        end else begin
            if (w_wr_con) begin
                r_tx_int_en <= writedata[0];
                r_rx_int_en <= writedata[1];
            end
            if (w_tx_end)      r_tx_done <= 1'b1;
            else if (w_rd_con) r_tx_done <= 1'b0;
            if (w_rx_ok)       r_rx_valid <= 1'b1;
            else if (w_rd_rxd) r_rx_valid <= 1'b0;
            if (w_rx_ok & r_rx_valid) r_overrun <= 1'b1;
            else if (w_rd_con)        r_overrun <= 1'b0;
            if (w_rx_bad)      r_frame_err <= 1'b1;
            else if (w_rd_con) r_frame_err <= 1'b0;
            if (w_rx_ok)       r_rxd <= r_rx_shift;
        end
    end

    // Load data mux; TXD is write-only and reads back as zero.
    always_comb begin
        readdata = 32'h0;
        if (read_enable) begin
            if (w_sel_rxd)
                readdata = {24'h0, r_rxd};
            else if (w_sel_con)
                readdata = {25'h0, r_overrun, r_frame_err, w_tx_busy,
                            r_rx_valid, r_tx_done, r_rx_int_en, r_tx_int_en};
        end
    end

    assign irq = (r_tx_done & r_tx_int_en) | (r_rx_valid & r_rx_int_en);

endmodule

// File: tb/tb_uart_periph.sv
// tb_uart_periph: directed + randomized bench for uart_periph (BAUD_DIV = 4).
// The reference model tracks the CON/RXD contents as abstract flags updated
// per completed frame and per register access.
module tb_uart_periph;

    localparam int          BD   = 4;
    localparam int          BITC = 16 * BD;
    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        read_enable = 1'b0;
    logic        write_enable = 1'b0;
    logic [31:0] address = 32'h0;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic        Uart_Rx = 1'b1;
    logic        Uart_Tx;
    logic        irq;

    uart_periph #(.BAUD_DIV(BD)) dut (
        .clk(clk), .reset(reset), .read_enable(read_enable),
        .write_enable(write_enable), .address(address), .writedata(writedata),
        .readdata(readdata), .Uart_Rx(Uart_Rx), .Uart_Tx(Uart_Tx), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit tx_log [0:65535];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < 65536) tx_log[cyc] <= Uart_Tx;

    // Reference model state
    bit       m_txie, m_rxie, m_txdone, m_rxv, m_fe, m_ov;
    bit [7:0] m_rxd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_con(input bit busy);
        return {25'h0, m_ov, m_fe, busy, m_rxv, m_txdone, m_rxie, m_txie};
    endfunction

    function automatic bit exp_irq();
        return (m_txdone & m_txie) | (m_rxv & m_rxie);
    endfunction

    task automatic model_reset();
        m_txie = 0; m_rxie = 0; m_txdone = 0; m_rxv = 0; m_fe = 0; m_ov = 0; m_rxd = 8'h0;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, output int w);
        @(negedge clk);
        write_enable = 1'b1; address = a; writedata = d;
        @(negedge clk);
        write_enable = 1'b0; address = 32'h0; writedata = 32'h0;
        w = cyc;
    endtask

    task automatic set_con(input bit [1:0] ie);
        int w;
        cpu_write(A_CON, {$urandom_range(0, 32'h3fff_ffff), ie}, w);
        m_txie = ie[0]; m_rxie = ie[1];
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        read_enable = 1'b1; address = a;
        #1 d = readdata;
        @(negedge clk);
        read_enable = 1'b0; address = 32'h0;
    endtask

    task automatic read_con(input string tag, input bit busy);
        logic [31:0] d;
        chk({tag, "_irq"}, {31'h0, irq}, {31'h0, exp_irq()});
        cpu_read(A_CON, d);
        chk(tag, d, exp_con(busy));
        m_txdone = 0; m_fe = 0; m_ov = 0;
    endtask

    task automatic read_rxd(input string tag);
        logic [31:0] d;
        cpu_read(A_RXD, d);
        chk(tag, d, {24'h0, m_rxd});
        m_rxv = 0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Drive one 8N1 frame, then fold its outcome into the model.
    task automatic send_rx(input bit [7:0] b, input bit stop_ok);
        bit [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            Uart_Rx = fr[k];
            repeat (BITC) @(negedge clk);
        end
        Uart_Rx = 1'b1;
        repeat (8) @(negedge clk);
        if (stop_ok) begin
            if (m_rxv) m_ov = 1;
            m_rxv = 1;
            m_rxd = b;
        end else begin
            m_fe = 1;
        end
    endtask

    // Frame written on edge w must show start/data(LSB first)/stop, each 64 clk.
    task automatic check_tx(input string tag, input int w, input bit [7:0] b);
        bit [9:0] seq;
        seq = {1'b1, b, 1'b0};
        chk({tag, "_pre"}, {31'h0, tx_log[w-1]}, 32'h1);
        chk({tag, "_edge"}, {31'h0, tx_log[w]}, 32'h0);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("%s_b%0d_early", tag, k), {31'h0, tx_log[w + BITC*k + 2]}, {31'h0, seq[k]});
            chk($sformatf("%s_b%0d_late", tag, k), {31'h0, tx_log[w + BITC*k + 58]}, {31'h0, seq[k]});
        end
    endtask

    initial begin
        logic [31:0] d;
        int w, w2;
        bit [7:0] rb, tb;
        bit ok, do_tx;

        model_reset();
        // Reset state while held
        repeat (3) @(negedge clk);
        read_enable = 1'b1; address = A_CON; #1;
        chk("rst_hold_con", readdata, 32'h0);
        chk("rst_hold_tx", {31'h0, Uart_Tx}, 32'h1);
        chk("rst_hold_irq", {31'h0, irq}, 32'h0);
        read_enable = 1'b0; address = 32'h0;
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        read_con("rst_con", 0);
        read_rxd("rst_rxd");

        // Register access rules
        cpu_write(A_CON, 32'hFFFF_FFFF, w); m_txie = 1; m_rxie = 1;
        read_con("con_wr", 0);
        cpu_write(32'h4000_0024, 32'hFFFF_FFFF, w);
        cpu_write(A_RXD, 32'h0000_00FF, w);
        cpu_read(32'h4000_0024, d); chk("rd_unmapped", d, 32'h0);
        cpu_read(A_TXD, d);         chk("rd_txd", d, 32'h0);
        read_rxd("rxd_wr_ignored");
        address = A_CON; #1; chk("rd_noen", readdata, 32'h0); address = 32'h0;
        read_con("con_unch", 0);

        // TX 0x5A with tx interrupt
        set_con(2'b01);
        cpu_write(A_TXD, 32'h0000_005A, w);
        wait_cyc(w + 100); read_con("busy1", 1);
        wait_cyc(w + 300); read_con("busy2", 1);
        wait_cyc(w + 632); read_con("busy3", 1);
        wait_cyc(w + 645); m_txdone = 1;
        chk("tx_irq", {31'h0, irq}, 32'h1);
        read_con("tx_done", 0);
        chk("tx_irq_clr", {31'h0, irq}, 32'h0);
        check_tx("tx5A", w, 8'h5A);

        // RX 0xA3
        set_con(2'b10);
        send_rx(8'hA3, 1);
        read_con("rxA3_con", 0);
        read_rxd("rxA3");
        read_con("rxA3_after", 0);

        // Overrun
        send_rx(8'h11, 1);
        send_rx(8'h22, 1);
        read_con("ovr_con", 0);
        read_rxd("ovr_rxd");
        read_con("ovr_clr", 0);

        // Low stop bit
        send_rx(8'h5C, 0);
        read_con("ferr_con", 0);
        read_con("ferr_clr", 0);

        // 2-clk glitch is a false start; a real frame still follows cleanly
        @(negedge clk); Uart_Rx = 1'b0;
        repeat (2) @(negedge clk); Uart_Rx = 1'b1;
        repeat (120) @(negedge clk);
        read_con("glitch", 0);
        send_rx(8'h6B, 1);
        read_rxd("post_glitch");

        // Second TXD write while busy is dropped
        set_con(2'b00);
        cpu_write(A_TXD, 32'h0000_003C, w);
        repeat (8) @(negedge clk);
        cpu_write(A_TXD, 32'h0000_00C5, w2);
        wait_cyc(w + 760);
        check_tx("txdbl", w, 8'h3C);
        chk("txdbl_idle", {31'h0, tx_log[w + 720]}, 32'h1);
        m_txdone = 1;
        read_con("txdbl_con", 0);

        // Reset during TX data bit 3
        send_rx(8'h77, 1);
        set_con(2'b11);
        cpu_write(A_TXD, 32'h0000_00F0, w);
        wait_cyc(w + 4*BITC + 20);
        chk("pre_rst_tx", {31'h0, Uart_Tx}, 32'h0);
        chk("pre_rst_irq", {31'h0, irq}, 32'h1);
        reset = 1'b0; #1;
        chk("rst_tx", {31'h0, Uart_Tx}, 32'h1);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        read_enable = 1'b1; address = A_CON; #1; chk("rst_con_mid", readdata, 32'h0);
        address = A_RXD; #1; chk("rst_rxd_mid", readdata, 32'h0);
        read_enable = 1'b0; address = 32'h0;
        repeat (3) @(negedge clk); reset = 1'b1;
        model_reset();
        read_con("post_rst", 0);
        cpu_write(A_TXD, 32'h0000_0096, w);
        wait_cyc(w + 650);
        check_tx("tx_post_rst", w, 8'h96);
        m_txdone = 1;
        read_con("post_rst_done", 0);

        // Randomized full-duplex traffic
        for (int it = 0; it < 10; it++) begin
            set_con(2'($urandom_range(0, 3)));
            rb = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            do_tx = 1'($urandom_range(0, 1));
            tb = 8'($urandom);
            if (do_tx) cpu_write(A_TXD, {24'h0, tb}, w);
            send_rx(rb, ok);
            if (do_tx) begin
                wait_cyc(w + 650);
                check_tx($sformatf("rnd%0d_tx", it), w, tb);
                m_txdone = 1;
            end
            if ($urandom_range(0, 1) == 1) read_rxd($sformatf("rnd%0d_rxd", it));
            if ($urandom_range(0, 2) != 0) read_con($sformatf("rnd%0d_con", it), 0);
        end
        read_con("final_con", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_periph.md
UART_PERIPH -- requirements
Module: uart_periph

Interface
REQ-001 Parameter BAUD_DIV, default 325, is the number of clk cycles per oversample tick; 16 ticks make one bit (50 MHz -> 9600 baud).
REQ-002 clk  input  1  core clock, the same clock that drives the pipeline registers.
REQ-003 reset  input  1  reset, asynchronous and active-low.
REQ-004 read_enable  input  1  MEM-stage load strobe.
REQ-005 write_enable  input  1  MEM-stage store strobe.
REQ-006 address  input  32  byte address from ALUOUT_MEM.
REQ-007 writedata  input  32  store data.
REQ-008 readdata  output  32  load data, combinational.
REQ-009 Uart_Rx  input  1  serial input, asynchronous to clk.
REQ-010 Uart_Tx  output  1  serial output, registered, idle high.
REQ-011 irq  output  1  level interrupt request to Control.

Function
REQ-012 Register map:
- 0x40000018 TXD: write-only, [7:0].
- 0x4000001C RXD: read-only, [7:0].
- 0x40000020 CON:
  - bit0 tx_int_en (R/W)
  - bit1 rx_int_en (R/W)
  - bit2 tx_done
  - bit3 rx_valid
  - bit4 tx_busy
  - bit5 frame_err
  - bit6 overrun
  - bits 31:7 read 0.
REQ-013 readdata behaviour:
- When read_enable is low, or the address is unmapped: 32'h0.
- Otherwise: the selected register, zero-extended.
REQ-014 Writes to unmapped addresses, RXD, or CON bits [31:2] have no effect; a write to CON updates bits [1:0] on the clock edge.
REQ-015 Tick generator: free-running counter 0..BAUD_DIV-1; it pulses tick for one clk when it wraps.
REQ-016 TX FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
REQ-017 A TXD write in IDLE latches writedata[7:0] and enters START on the same edge. From that edge:
- tx_busy = 1.
- Uart_Tx = 0.
REQ-018 Each TX bit is held for 16 ticks. The first bit may be short by at most one tick period.
REQ-019 Data bits are sent LSB first (8 bits), then the stop bit (1) for 16 ticks.
REQ-020 At the end of STOP:
- FSM returns to IDLE.
- tx_busy clears.
- tx_done sets.
REQ-021 A TXD write while tx_busy = 1 is ignored; the frame in flight is unaffected.
REQ-022 RX path: Uart_Rx passes through a 2-flop synchronizer before any use.
REQ-023 RX FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
REQ-024 In RX IDLE, a synchronized high-to-low transition enters START and restarts the RX tick count.
REQ-025 In START, the line is sampled at tick 8; if it is high, this is a false start and the FSM returns to IDLE with no flag change.
REQ-026 Data bits are sampled every 16 ticks after the start-bit mid-sample and shifted in LSB first.
REQ-027 Stop bit sampled high:
- RXD loads the byte.
- rx_valid sets.
- If rx_valid was already 1, overrun also sets and RXD is overwritten.
REQ-028 Stop bit sampled low:
- frame_err sets.
- RXD and rx_valid are unchanged.
- FSM returns to IDLE.
REQ-029 A read of CON clears tx_done, frame_err and overrun. A read of RXD clears rx_valid.
REQ-030 If a set event and a clearing read happen in the same cycle, the set wins (the flag reads 1 afterwards).
REQ-031 irq = (tx_done & tx_int_en) | (rx_valid & rx_int_en), registered-flag based, no extra delay.
REQ-032 TX and RX operate fully independently; full-duplex loopback (Uart_Tx tied to Uart_Rx) shall work.

Reset
REQ-033 While reset = 0, asynchronously:
- Uart_Tx = 1.
- irq = 0.
- All CON bits, RXD, the tick counter and the shift registers = 0.
- Both FSMs in IDLE.
- readdata = 0 (read_enable is don't-care during reset).
REQ-034 Reset asserted mid-frame aborts the frame and raises no flag. After release, the next start bit is detected normally.

Verification (BAUD_DIV = 4, so one bit = 64 clk)
REQ-035 Write TXD = 0x5A -> Uart_Tx carries the bit sequence 0,0,1,0,1,1,0,1,0,1 with each bit 64±4 clk. tx_busy = 1 throughout. Then tx_done = 1. With tx_int_en = 1, irq = 1; a CON read returns 0x05 and clears irq.
REQ-036 Drive 0xA3 8N1 on Uart_Rx -> rx_valid = 1. RXD read returns 0x000000A3. rx_valid = 0 afterwards.
REQ-037 Receive 0x11 then 0x22 without reading RXD -> RXD = 0x22, overrun = 1. A CON read clears overrun.
REQ-038 Stimulus cases:
- Low stop bit -> frame_err = 1, rx_valid = 0.
- 2-clk low glitch on Uart_Rx -> false start, no flag change.
REQ-039 Write TXD twice, 10 clk apart -> only the first byte is transmitted.
REQ-040 Assert reset at data bit 3 -> Uart_Tx = 1 immediately, all flags 0. After release, the next write transmits a clean frame.
